// File: rtl/mig_tt_pkg.sv
// Shared types and helpers for the MIG truth-table engine.
// Holds the state enum, the gate entry layout and the width/projection helpers.
package mig_tt_pkg;

  // Gate entries are stored at a fixed maximum width so one struct fits any legal configuration.
  localparam int SEL_MAX_W = 8;
  localparam int TT_MAX_W  = 1024;

  typedef enum logic [1:0] {IDLE, EVAL, OUT} state_t;

  typedef struct packed {
    logic [SEL_MAX_W-1:0] sel_a;
    logic [SEL_MAX_W-1:0] sel_b;
    logic [SEL_MAX_W-1:0] sel_c;
    logic [2:0]           inv;
  } gate_entry_t;

  function automatic int f_tt_w(input int num_in);
    return 1 << num_in;
  endfunction

  function automatic int f_sel_w(input int num_in, input int max_gates);
    return $clog2(num_in + max_gates + 1);
  endfunction

  function automatic int f_cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Bit m of the projection of input var_idx is bit var_idx of the minterm index m.
  function automatic logic [TT_MAX_W-1:0] f_proj_vec(input int var_idx);
    logic [TT_MAX_W-1:0] v;
    for (int m = 0; m < TT_MAX_W; m++) begin
      v[m] = (((m >> var_idx) & 1) == 1);
    end
    return v;
  endfunction

endpackage

// File: rtl/mig_maj_slice.sv
// Combinational evaluation of one MIG gate over the whole truth table:
// fanin select, optional complement and bitwise majority.
module mig_maj_slice
  import mig_tt_pkg::*;
#(
  parameter int NUM_IN    = 7,
  parameter int MAX_GATES = 16,
  parameter int TT_W      = 128,
  parameter int GI_W      = 4
) (
  input  gate_entry_t     i_entry,
  input  logic [GI_W-1:0] i_gateIdx,
  input  logic [TT_W-1:0] i_proj    [NUM_IN],
  input  logic [TT_W-1:0] i_results [MAX_GATES],
  output logic [TT_W-1:0] o_result,
  output logic            o_err
);

  logic [SEL_MAX_W-1:0] w_sel [3];
  logic [TT_W-1:0]      w_fan [3];
  logic [2:0]           w_bad;

  assign w_sel[0] = i_entry.sel_a;
  assign w_sel[1] = i_entry.sel_b;
  assign w_sel[2] = i_entry.sel_c;

  // Only already-computed gates are legal sources; anything else reads as 0 and is flagged.
  always_comb begin
    for (int f = 0; f < 3; f++) begin
      w_fan[f] = '0;
      w_bad[f] = (w_sel[f] != '0);
      for (int k = 0; k < NUM_IN; k++) begin
        if (int'(w_sel[f]) == k + 1) begin
          w_fan[f] = i_proj[k];
          w_bad[f] = 1'b0;
        end
      end
      for (int j = 0; j < MAX_GATES; j++) begin
        if (int'(w_sel[f]) == NUM_IN + 1 + j && j < int'(i_gateIdx)) begin
          w_fan[f] = i_results[j];
          w_bad[f] = 1'b0;
        end
      end
      w_fan[f] = w_fan[f] ^ {TT_W{i_entry.inv[f]}};
    end
  end

  assign o_result = (w_fan[0] & w_fan[1]) | (w_fan[0] & w_fan[2]) | (w_fan[1] & w_fan[2]);
  assign o_err    = |w_bad;

endmodule

// File: rtl/mig_tt_engine.sv
// Programmable MIG truth-table engine: one gate per cycle, result streamed in OUT_W words.
// Optional popcount output enabled by defining MIG_TT_ONES_COUNT_EN.
module mig_tt_engine
  import mig_tt_pkg::*;
#(
  parameter int NUM_IN    = 7,
  parameter int MAX_GATES = 16,
  parameter int OUT_W     = 32
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      prog_valid,
  output logic                                      prog_ready,
  input  logic [$clog2(MAX_GATES)-1:0]              prog_addr,
  input  logic [3*f_sel_w(NUM_IN, MAX_GATES)-1:0]   prog_sel,
  input  logic [2:0]                                prog_inv,
  input  logic [$clog2(MAX_GATES+1)-1:0]            num_gates,
  input  logic                                      start,
  output logic                                      busy,
  output logic                                      tt_valid,
  input  logic                                      tt_ready,
  output logic [OUT_W-1:0]                          tt_data,
  output logic                                      tt_last,
  output logic                                      done,
  output logic                                      err
`ifdef MIG_TT_ONES_COUNT_EN
  ,
  output logic [NUM_IN:0]                           ones_cnt
`endif
);

  localparam int TT_W      = f_tt_w(NUM_IN);
  localparam int SEL_W     = f_sel_w(NUM_IN, MAX_GATES);
  localparam int GI_W      = f_cnt_w(MAX_GATES);
  localparam int NUM_WORDS = TT_W / OUT_W;
  localparam int WI_W      = f_cnt_w(NUM_WORDS);

  if (TT_W % OUT_W != 0) begin : g_badOutW
    $error("mig_tt_engine: TT_W must be a multiple of OUT_W");
  end
  if (SEL_W > SEL_MAX_W || TT_W > TT_MAX_W) begin : g_badSize
    $error("mig_tt_engine: configuration exceeds package maximum widths");
  end

  state_t          r_state, w_nextState;
  gate_entry_t     r_gateMem [MAX_GATES];
  logic [TT_W-1:0] r_results [MAX_GATES];
  logic [GI_W-1:0] r_gateIdx, r_lastIdx;
  logic [WI_W-1:0] r_wordIdx;
  logic            r_err, r_done;

  gate_entry_t      w_progEntry;
  logic             w_progWe, w_startOk, w_gateActive, w_evalDone, w_lastWord, w_lastHs;
  logic             w_gateErr;
  logic [TT_W-1:0]  w_gateOut, w_final;
  logic [TT_W-1:0]  w_proj  [NUM_IN];
  logic [OUT_W-1:0] w_words [NUM_WORDS];

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_proj
    localparam logic [TT_MAX_W-1:0] P_FULL = f_proj_vec(gi);
    assign w_proj[gi] = P_FULL[TT_W-1:0];
  end

  assign w_final = r_results[r_lastIdx];
  for (genvar gw = 0; gw < NUM_WORDS; gw++) begin : g_words
    assign w_words[gw] = w_final[gw*OUT_W +: OUT_W];
  end

  assign w_progEntry = '{sel_a: SEL_MAX_W'(prog_sel[SEL_W-1:0]),
                         sel_b: SEL_MAX_W'(prog_sel[2*SEL_W-1:SEL_W]),
                         sel_c: SEL_MAX_W'(prog_sel[3*SEL_W-1:2*SEL_W]),
                         inv:   prog_inv};
  assign w_progWe  = prog_valid && prog_ready && (int'(prog_addr) < MAX_GATES);
  assign w_startOk = (r_state == IDLE) && start && (num_gates != '0) &&
                     (int'(num_gates) <= MAX_GATES);
  assign w_lastWord = (int'(r_wordIdx) == NUM_WORDS - 1);
  assign w_lastHs   = tt_valid && tt_ready && tt_last;

`ifdef MIG_TT_ONES_COUNT_EN
  logic            r_cntPhase;
  logic [NUM_IN:0] r_onesCnt, w_popcnt;

  always_comb begin
    w_popcnt = '0;
    for (int b = 0; b < TT_W; b++) begin
      w_popcnt = w_popcnt + {{NUM_IN{1'b0}}, w_final[b]};
    end
  end

  assign w_gateActive = (r_state == EVAL) && !r_cntPhase;
  assign w_evalDone   = r_cntPhase;
  assign ones_cnt     = r_onesCnt;
`else
  assign w_gateActive = (r_state == EVAL);
  assign w_evalDone   = (r_gateIdx == r_lastIdx);
`endif

  mig_maj_slice #(
    .NUM_IN    (NUM_IN),
    .MAX_GATES (MAX_GATES),
    .TT_W      (TT_W),
    .GI_W      (GI_W)
  ) u_slice (
    .i_entry   (r_gateMem[r_gateIdx]),
    .i_gateIdx (r_gateIdx),
    .i_proj    (w_proj),
    .i_results (r_results),
    .o_result  (w_gateOut),
    .o_err     (w_gateErr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_startOk)  w_nextState = EVAL;
      EVAL:    if (w_evalDone) w_nextState = OUT;
      OUT:     if (w_lastHs)   w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    prog_ready = (r_state == IDLE);
    busy       = (r_state != IDLE);
    tt_valid   = (r_state == OUT);
    tt_last    = tt_valid && w_lastWord;
    tt_data    = tt_valid ? w_words[r_wordIdx] : '0;
  end

  // Program and result storage carry no reset; stale contents are never observed outside OUT.
  always_ff @(posedge clk) begin
    if (!rst && w_progWe) begin
      r_gateMem[prog_addr] <= w_progEntry;
    end
    if (w_gateActive) begin
      r_results[r_gateIdx] <= w_gateOut;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lastIdx  <= '0;
      r_gateIdx  <= '0;
      r_wordIdx  <= '0;
      r_err      <= 1'b0;
      r_done     <= 1'b0;
`ifdef MIG_TT_ONES_COUNT_EN
      r_cntPhase <= 1'b0;
      r_onesCnt  <= '0;
`endif
    end else begin
      r_done <= w_lastHs;
      if (w_startOk) begin
        r_lastIdx  <= GI_W'(num_gates - 1'b1);
        r_gateIdx  <= '0;
        r_wordIdx  <= '0;
        r_err      <= 1'b0;
`ifdef MIG_TT_ONES_COUNT_EN
        r_cntPhase <= 1'b0;
`endif
      end
      if (w_gateActive) begin
        r_err <= r_err | w_gateErr;
        if (r_gateIdx != r_lastIdx) begin
          r_gateIdx <= r_gateIdx + 1'b1;
        end
`ifdef MIG_TT_ONES_COUNT_EN
        else begin
          r_cntPhase <= 1'b1;
        end
`endif
      end
`ifdef MIG_TT_ONES_COUNT_EN
      if (r_state == EVAL && r_cntPhase) begin
        r_onesCnt <= w_popcnt;
      end
`endif
      if (tt_valid && tt_ready) begin
        r_wordIdx <= r_wordIdx + 1'b1;
      end
    end
  end

  assign done = r_done;
  assign err  = r_err;

endmodule
